// File: rtl/frcr_timer_cmp.sv
`default_nettype none
// ============================================================================
// Module      : frcr_timer_cmp
// Description : Free-running prescaled counter with P_CH one-shot/periodic
//               compare channels, pending/overrun flags and a single
//               lowest-index-first valid/ack interrupt port.
// Revision    : 1.0 - initial release
// ============================================================================
module frcr_timer_cmp #(
    parameter int P_WIDTH = 64,
    parameter int P_CH    = 4,
    parameter int P_CH_W  = 2,
    parameter int P_PRE_W = 8
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic               iRUN,
    input  logic [P_PRE_W-1:0] iPRESCALE,
    input  logic               iCNT_WR_ENA,
    input  logic [P_WIDTH-1:0] iCNT_WR_DATA,
    output logic [P_WIDTH-1:0] oCOUNTER,
    input  logic               iCH_WR_ENA,
    input  logic [P_CH_W-1:0]  iCH_WR_SEL,
    input  logic [P_WIDTH-1:0] iCH_WR_CMP,
    input  logic [P_WIDTH-1:0] iCH_WR_PERIOD,
    input  logic               iCH_WR_MODE,
    input  logic               iCH_WR_ARM,
    output logic [P_CH-1:0]    oCH_PENDING,
    output logic [P_CH-1:0]    oCH_OVERRUN,
    output logic               oIRQ_VALID,
    output logic [P_CH_W-1:0]  oIRQ_NUM,
    input  logic               iIRQ_ACK
);

    logic [P_WIDTH-1:0] r_counter;
    logic [P_PRE_W-1:0] r_pc;
    logic [P_WIDTH-1:0] r_cmp    [P_CH];
    logic [P_WIDTH-1:0] r_period [P_CH];
    logic [P_CH-1:0]    r_mode;
    logic [P_CH-1:0]    r_armed;
    logic [P_CH-1:0]    r_pending;
    logic [P_CH-1:0]    r_overrun;

    logic               w_tick;
    logic [P_WIDTH-1:0] w_next;
    logic [P_CH-1:0]    w_hit;
    logic [P_CH-1:0]    w_wr;
    logic [P_CH-1:0]    w_ack;
    logic               w_irq_valid;
    logic [P_CH_W-1:0]  w_irq_num;

    // A counter load suppresses the tick, so a loaded value can never hit.
    assign w_tick = iRUN && (r_pc == iPRESCALE) && !iCNT_WR_ENA;
    assign w_next = r_counter + 1'b1;

    // Counter and prescaler: load beats counting, iRUN=0 holds both.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_counter <= '0;
            r_pc      <= '0;
        end else if (iCNT_WR_ENA) begin
            r_counter <= iCNT_WR_DATA;
            r_pc      <= '0;
        end else if (w_tick) begin
            r_counter <= w_next;
            r_pc      <= '0;
        end else if (iRUN) begin
            r_pc      <= r_pc + 1'b1;
        end
    end

    // Lowest pending index wins the interrupt port; 0 when nothing pends.
    always_comb begin
        w_irq_num = '0;
        for (int i = P_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_irq_num = P_CH_W'(i);
            end
        end
    end

    assign w_irq_valid = |r_pending;

    // Per-channel hit, configuration-write and acknowledge decode.
    always_comb begin
        w_hit = '0;
        w_wr  = '0;
        w_ack = '0;
        for (int k = 0; k < P_CH; k++) begin
            w_hit[k] = w_tick && r_armed[k] && (w_next == r_cmp[k]);
            w_wr[k]  = iCH_WR_ENA && (iCH_WR_SEL == P_CH_W'(k));
            w_ack[k] = iIRQ_ACK && w_irq_valid && (w_irq_num == P_CH_W'(k));
        end
    end

    // Channel state: a write wins over a same-cycle hit; a hit wins over an
    // ack, and an ack-plus-hit is not counted as an overrun.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            for (int k = 0; k < P_CH; k++) begin
                r_cmp[k]    <= '0;
                r_period[k] <= '0;
            end
            r_mode    <= '0;
            r_armed   <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            for (int k = 0; k < P_CH; k++) begin
                if (w_wr[k]) begin
                    r_cmp[k]     <= iCH_WR_CMP;
                    r_period[k]  <= iCH_WR_PERIOD;
                    r_mode[k]    <= iCH_WR_MODE;
                    r_armed[k]   <= iCH_WR_ARM;
                    r_pending[k] <= 1'b0;
                    r_overrun[k] <= 1'b0;
                end else if (w_hit[k]) begin
                    r_pending[k] <= 1'b1;
                    if (r_pending[k] && !w_ack[k]) begin
                        r_overrun[k] <= 1'b1;
                    end
                    if (r_mode[k] && (r_period[k] != '0)) begin
                        r_cmp[k] <= r_cmp[k] + r_period[k];
                    end else begin
                        r_armed[k] <= 1'b0;
                    end
                end else if (w_ack[k]) begin
                    r_pending[k] <= 1'b0;
                end
            end
        end
    end

    assign oCOUNTER    = r_counter;
    assign oCH_PENDING = r_pending;
    assign oCH_OVERRUN = r_overrun;
    assign oIRQ_VALID  = w_irq_valid;
    assign oIRQ_NUM    = w_irq_num;

endmodule
`default_nettype wire

// File: tb/tb_frcr_timer_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_frcr_timer_cmp
// Description : Directed scoreboard bench for frcr_timer_cmp. Stimulus pushes
//               hand-computed snapshots; a monitor pops and compares them at
//               the falling edge of the cycle they describe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frcr_timer_cmp;

    localparam int W   = 64;
    localparam int CH  = 4;
    localparam int CHW = 2;
    localparam int PW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [PW-1:0]  prescale;
    logic           cnt_wr_ena;
    logic [W-1:0]   cnt_wr_data;
    logic [W-1:0]   counter;
    logic           ch_wr_ena;
    logic [CHW-1:0] ch_wr_sel;
    logic [W-1:0]   ch_wr_cmp;
    logic [W-1:0]   ch_wr_period;
    logic           ch_wr_mode;
    logic           ch_wr_arm;
    logic [CH-1:0]  pending;
    logic [CH-1:0]  overrun;
    logic           irq_valid;
    logic [CHW-1:0] irq_num;
    logic           irq_ack;

    typedef struct {
        string          name;
        logic [W-1:0]   cnt;
        logic [CH-1:0]  pend;
        logic [CH-1:0]  ovr;
        logic           valid;
        logic [CHW-1:0] num;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    frcr_timer_cmp #(
        .P_WIDTH (W),
        .P_CH    (CH),
        .P_CH_W  (CHW),
        .P_PRE_W (PW)
    ) dut (
        .iCLOCK        (clk),
        .iRESET_SYNC   (rst),
        .iRUN          (run),
        .iPRESCALE     (prescale),
        .iCNT_WR_ENA   (cnt_wr_ena),
        .iCNT_WR_DATA  (cnt_wr_data),
        .oCOUNTER      (counter),
        .iCH_WR_ENA    (ch_wr_ena),
        .iCH_WR_SEL    (ch_wr_sel),
        .iCH_WR_CMP    (ch_wr_cmp),
        .iCH_WR_PERIOD (ch_wr_period),
        .iCH_WR_MODE   (ch_wr_mode),
        .iCH_WR_ARM    (ch_wr_arm),
        .oCH_PENDING   (pending),
        .oCH_OVERRUN   (overrun),
        .oIRQ_VALID    (irq_valid),
        .oIRQ_NUM      (irq_num),
        .iIRQ_ACK      (irq_ack)
    );

    // Monitor: every snapshot queued during a cycle is checked at its falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (counter !== e.cnt || pending !== e.pend || overrun !== e.ovr ||
                irq_valid !== e.valid || irq_num !== e.num) begin
                bad++;
                $display("FAIL %s: got cnt=%0d pend=%b ovr=%b valid=%b num=%0d, want cnt=%0d pend=%b ovr=%b valid=%b num=%0d",
                         e.name, counter, pending, overrun, irq_valid, irq_num,
                         e.cnt, e.pend, e.ovr, e.valid, e.num);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_st(input string name, input logic [W-1:0] cnt,
                             input logic [CH-1:0] pend, input logic [CH-1:0] ovr,
                             input logic valid, input logic [CHW-1:0] num);
        exp_t e;
        e.name  = name;
        e.cnt   = cnt;
        e.pend  = pend;
        e.ovr   = ovr;
        e.valid = valid;
        e.num   = num;
        q.push_back(e);
    endtask

    task automatic cfg(input logic [CHW-1:0] sel, input logic [W-1:0] cmpv,
                       input logic [W-1:0] per, input logic mode, input logic arm);
        ch_wr_sel    = sel;
        ch_wr_cmp    = cmpv;
        ch_wr_period = per;
        ch_wr_mode   = mode;
        ch_wr_arm    = arm;
        ch_wr_ena    = 1'b1;
        step(1);
        ch_wr_ena    = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        cnt_wr_data = v;
        cnt_wr_ena  = 1'b1;
        step(1);
        cnt_wr_ena  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; run = 1'b0; prescale = '0;
        cnt_wr_ena = 1'b0; cnt_wr_data = '0;
        ch_wr_ena = 1'b0; ch_wr_sel = '0; ch_wr_cmp = '0; ch_wr_period = '0;
        ch_wr_mode = 1'b0; ch_wr_arm = 1'b0; irq_ack = 1'b0;

        // Reset state
        step(2);
        expect_st("reset", 0, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Free count with prescale 0: 0,1,2,3
        rst = 1'b0; run = 1'b1;
        expect_st("count0", 0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1); expect_st("count1", 1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1); expect_st("count2", 2, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1); expect_st("count3", 3, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Prescale 3: every 4th edge after a load
        prescale = 8'd3;
        load(0);
        step(3); expect_st("pre3_hold", 0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1); expect_st("pre3_inc1", 1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(3); expect_st("pre3_hold2", 1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1); expect_st("pre3_inc2", 2, 4'b0000, 4'b0000, 1'b0, 2'd0);
        prescale = 8'd0;

        // Ch0 one-shot at 10, then ack, then no re-hit
        run = 1'b0;
        cfg(0, 10, 0, 1'b0, 1'b1);
        load(0);
        expect_st("frozen", 0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        run = 1'b1;
        step(9);  expect_st("os_before", 9, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1);  expect_st("os_hit", 10, 4'b0001, 4'b0000, 1'b1, 2'd0);
        irq_ack = 1'b1;
        step(1);  expect_st("os_ack", 11, 4'b0000, 4'b0000, 1'b0, 2'd0);
        irq_ack = 1'b0;
        load(9);
        step(1);  expect_st("os_disarmed", 10, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Ch1 periodic cmp=5 period=3
        run = 1'b0;
        cfg(1, 5, 3, 1'b1, 1'b1);
        load(0);
        run = 1'b1;
        step(5);  expect_st("per_hit5", 5, 4'b0010, 4'b0000, 1'b1, 2'd1);
        step(3);  expect_st("per_hit8_ovr", 8, 4'b0010, 4'b0010, 1'b1, 2'd1);
        step(1);
        irq_ack = 1'b1;
        step(1);  expect_st("per_ack", 10, 4'b0000, 4'b0010, 1'b0, 2'd0);
        irq_ack = 1'b0;
        step(1);  expect_st("per_hit11", 11, 4'b0010, 4'b0010, 1'b1, 2'd1);
        run = 1'b0;
        cfg(1, 0, 0, 1'b0, 1'b0);
        expect_st("wr_clears", 11, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Ch2 and ch3 both at 20
        cfg(2, 20, 0, 1'b0, 1'b1);
        cfg(3, 20, 0, 1'b0, 1'b1);
        load(0);
        run = 1'b1;
        step(20); expect_st("dual_hit", 20, 4'b1100, 4'b0000, 1'b1, 2'd2);
        irq_ack = 1'b1;
        step(1);  expect_st("dual_ack1", 21, 4'b1000, 4'b0000, 1'b1, 2'd3);
        step(1);  expect_st("dual_ack2", 22, 4'b0000, 4'b0000, 1'b0, 2'd0);
        irq_ack = 1'b0;

        // Wrap from all-ones hits cmp=0
        run = 1'b0;
        cfg(0, 0, 0, 1'b0, 1'b1);
        load({W{1'b1}});
        run = 1'b1;
        expect_st("wrap_before", {W{1'b1}}, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1);  expect_st("wrap_hit", 0, 4'b0001, 4'b0000, 1'b1, 2'd0);
        irq_ack = 1'b1;
        step(1);  expect_st("wrap_ack", 1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        irq_ack = 1'b0;

        // Load onto the compare value never hits
        run = 1'b0;
        cfg(0, 50, 0, 1'b0, 1'b1);
        run = 1'b1;
        load(50); expect_st("load_nohit", 50, 4'b0000, 4'b0000, 1'b0, 2'd0);
        step(1);  expect_st("load_after", 51, 4'b0000, 4'b0000, 1'b0, 2'd0);
        load(49);
        step(1);  expect_st("load_still_armed", 50, 4'b0001, 4'b0000, 1'b1, 2'd0);
        irq_ack = 1'b1;
        step(1);  expect_st("load_ack", 51, 4'b0000, 4'b0000, 1'b0, 2'd0);
        irq_ack = 1'b0;

        // Ack and hit on the same channel in one cycle
        run = 1'b0;
        cfg(1, 5, 1, 1'b1, 1'b1);
        load(0);
        run = 1'b1;
        step(5);  expect_st("ah_first", 5, 4'b0010, 4'b0000, 1'b1, 2'd1);
        irq_ack = 1'b1;
        step(1);  expect_st("ah_same", 6, 4'b0010, 4'b0000, 1'b1, 2'd1);
        irq_ack = 1'b0;
        step(1);  expect_st("ah_overrun", 7, 4'b0010, 4'b0010, 1'b1, 2'd1);
        run = 1'b0;
        cfg(1, 0, 0, 1'b0, 1'b0);

        // Channel write on the hit cycle drops the hit
        cfg(0, 30, 0, 1'b0, 1'b1);
        load(0);
        run = 1'b1;
        step(29); expect_st("wh_before", 29, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cfg(0, 30, 0, 1'b0, 1'b1);
        expect_st("wh_dropped", 30, 4'b0000, 4'b0000, 1'b0, 2'd0);
        load(29);
        step(1);  expect_st("wh_rearmed", 30, 4'b0001, 4'b0000, 1'b1, 2'd0);

        // Reset mid-operation
        rst = 1'b1;
        step(1);  expect_st("mid_reset", 0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;
        step(1);  expect_st("post_reset", 1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        load(29);
        step(1);  expect_st("post_reset_disarmed", 30, 4'b0000, 4'b0000, 1'b0, 2'd0);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frcr_timer_cmp.md
# frcr_timer_cmp

Parametrised free-running counter with prescaler and P_CH compare channels, each one-shot or periodic, raising pending flags that are serviced through a single valid/ack interrupt port. It is the next-generation scheduling timer for the core. It replaces the plain 64-bit load/increment counter and adds compare-based event generation for the scheduler and interrupt controller.

## Interface
- P_WIDTH, 64: counter, compare and period width.
- P_CH, 4: number of compare channels (2..16).
- P_CH_W, 2: channel index width; must equal clog2(P_CH).
- P_PRE_W, 8: prescaler width.

Clock and reset: one clock; reset is synchronous and active-high.

- iCLOCK  in  1  clock; all state updates on the rising edge.
- iRESET_SYNC  in  1  synchronous active-high reset.
- iRUN  in  1  counting enable; 0 freezes the counter and prescaler.
- iPRESCALE  in  P_PRE_W  counter advances once every iPRESCALE+1 enabled cycles.
- iCNT_WR_ENA  in  1  load counter.
- iCNT_WR_DATA  in  P_WIDTH  load value.
- oCOUNTER  out  P_WIDTH  current counter value.
- iCH_WR_ENA  in  1  write one channel's configuration.
- iCH_WR_SEL  in  P_CH_W  channel to write; values >= P_CH are ignored.
- iCH_WR_CMP  in  P_WIDTH  compare value.
- iCH_WR_PERIOD  in  P_WIDTH  reload increment for periodic mode.
- iCH_WR_MODE  in  1  0 = one-shot, 1 = periodic.
- iCH_WR_ARM  in  1  channel armed after the write.
- oCH_PENDING  out  P_CH  per-channel pending flags.
- oCH_OVERRUN  out  P_CH  sticky flag: a hit occurred while that channel was already pending.
- oIRQ_VALID  out  1  OR of oCH_PENDING.
- oIRQ_NUM  out  P_CH_W  lowest-index pending channel; 0 when none is pending.
- iIRQ_ACK  in  1  clears the pending flag of the oIRQ_NUM channel.

## Operation
- State:
  - counter (P_WIDTH) and prescale count pc (P_PRE_W).
  - Per channel: cmp, period, mode, armed, pending, overrun.
- Reset: every register is 0, so oCOUNTER=0, oCH_PENDING=0, oCH_OVERRUN=0, oIRQ_VALID=0, oIRQ_NUM=0, and all channels are disarmed.
- tick = iRUN && pc==iPRESCALE && !iCNT_WR_ENA.
  - On iRUN with no tick: pc <= pc+1.
  - On tick: pc <= 0 and counter <= counter+1, mod 2^P_WIDTH; all-ones wraps to 0.
- iCNT_WR_ENA has priority over counting:
  - counter <= iCNT_WR_DATA and pc <= 0.
  - The load never generates a hit, even if the loaded value equals a compare value.
- Hit for channel k: tick && armed[k] && (counter+1)==cmp[k]. Only increment transitions hit; skipped values never hit.
- On hit:
  - pending[k] <= 1; if pending[k] was already 1, overrun[k] <= 1.
  - Periodic with period!=0: cmp[k] <= cmp[k]+period, mod 2^P_WIDTH, and the channel stays armed.
  - One-shot, or period==0: armed[k] <= 0.
- Channel write to channel k:
  - Loads cmp, period, mode, armed from the write inputs.
  - Clears pending[k] and overrun[k].
  - Overrides a same-cycle hit on k; that hit is dropped entirely.
- iIRQ_ACK:
  - With oIRQ_VALID=1, clears pending[oIRQ_NUM] as sampled that cycle.
  - With oIRQ_VALID=0, ignored.
  - If a new hit on the same channel occurs in the same cycle, pending stays 1 and overrun is not set.
- Hits on several channels in one cycle all set their pending flags independently.

## Timing
- Counter and pending flags update on the same edge. oCH_PENDING[k] is first 1 in the cycle where oCOUNTER==cmp (old value).
- oIRQ_VALID and oIRQ_NUM are combinational from the pending registers. There is no extra latency, so they are valid in that same cycle.
- Ack to flag-clear latency is one edge: the next channel is presented in the cycle after the ack.
- With iPRESCALE=N and iRUN held high, the counter increments on every (N+1)th edge.
- The first increment after reset or after a counter load comes N+1 edges later.
- Dropping iRUN freezes pc and counter; they resume from the held values.
- iRESET_SYNC has priority over every input, including in mid-operation. All state returns to reset values on that edge.

## Test plan
- Reset, iRUN=1, iPRESCALE=0: oCOUNTER reads 0,1,2,3 on successive cycles. With iPRESCALE=3, the counter increments every 4th edge.
- Ch0 one-shot, cmp=10:
  - Pending rises in the cycle oCOUNTER==10; oIRQ_VALID=1 and oIRQ_NUM=0.
  - Ack clears it the next cycle, and no further hit occurs at 10+2^W.
- Ch1 periodic, cmp=5, period=3: hits at 5, 8, 11. With no acks, the hit at 8 sets oCH_OVERRUN[1]=1.
- Ch2 and ch3 both hit at 20:
  - oIRQ_NUM=2 first; after one ack, oIRQ_NUM=3; after the second ack, oIRQ_VALID=0.
- Counter wrap and load:
  - Counter loaded with all-ones and ch0 cmp=0: hit fires on the wrap.
  - Load 50 with ch0 cmp=50: no hit.
- Simultaneous events:
  - Ack and a new hit on the same channel in one cycle: pending stays 1 and overrun stays 0.
  - Channel write on the hit cycle: no pending.
  - iRESET_SYNC mid-count clears everything.
